cls_command_parser: RTL and testbench

- Receive-side counterpart of the PmodCLS command stream: consumes the ASCII byte stream our command lookup/SPI/UART path emits (e.g. 1B 5B 6A, digit strings) and decodes it into discrete display commands.
- Used as the model display end in loopback benches and as the command front end of the on-FPGA character display controller.
- Sits between a byte receiver (valid/ready) and the display write engine (valid/ready).

---
 rtl/cls_pkg.sv | 44 ++++
 rtl/cls_param_acc.sv | 25 ++
 rtl/cls_command_parser.sv | 155 +++++++++++++++
 tb/tb_cls_command_parser.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cls_pkg.sv
// Shared constants for the PmodCLS command stream: command codes, ASCII
// framing bytes and the receive-side parser state encoding.
package cls_pkg;

  localparam logic [3:0] CMD_CHAR       = 4'd0;
  localparam logic [3:0] CMD_CLEAR      = 4'd1;
  localparam logic [3:0] CMD_CURSOR     = 4'd2;
  localparam logic [3:0] CMD_ERASE_LINE = 4'd3;
  localparam logic [3:0] CMD_SET_MODE   = 4'd4;
  localparam logic [3:0] CMD_ERR        = 4'd15;

  localparam logic [7:0] ESC      = 8'h1B;
  localparam logic [7:0] LBRACKET = 8'h5B;
  localparam logic [7:0] SEMI     = 8'h3B;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ESC    = 2'd1,
    ST_CSI_P0 = 2'd2,
    ST_CSI_P1 = 2'd3
  } state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  // Final byte of a CSI sequence; CMD_ERR means "not a known command letter".
  function automatic logic [3:0] csi_final_code(input logic [7:0] b);
    logic [3:0] code;
    case (b)
      8'h6A:   code = CMD_CLEAR;
      8'h48:   code = CMD_CURSOR;
      8'h4B:   code = CMD_ERASE_LINE;
      8'h68:   code = CMD_SET_MODE;
      default: code = CMD_ERR;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/cls_param_acc.sv
// Saturating decimal parameter accumulator: value = value*10 + digit,
// clamped at 255.
module cls_param_acc (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  output logic [7:0] value
);

  logic [11:0] next_val;

  // Wide enough for 255*10+9, so the clamp compare sees the true sum.
  assign next_val = 12'(value) * 12'd10 + 12'(digit);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      value <= 8'd0;
    end else if (digit_valid) begin
      value <= (next_val > 12'd255) ? 8'hFF : next_val[7:0];
    end
  end

endmodule

// File: rtl/cls_command_parser.sv
// Receive-side PmodCLS parser: turns an ASCII/escape byte stream into
// discrete display commands with valid/ready on both sides.
module cls_command_parser
  import cls_pkg::*;
#(
  parameter int TIMEOUT = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [3:0] cmd_code,
  output logic [7:0] cmd_p0,
  output logic [7:0] cmd_p1,
  output logic       seq_abort,
  output state_t     state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // rx_ready only drops while a command is stalled downstream, so no
  // received byte is lost; cmd_* hold steady while cmd_valid && !cmd_ready.

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      nxt_state;
  logic [15:0] to_cnt;
  logic        accept;
  logic        emit;
  logic [3:0]  emit_code;
  logic [7:0]  emit_p0;
  logic [7:0]  emit_p1;
  logic [7:0]  acc0;
  logic [7:0]  acc1;
  logic        acc_clear;
  logic        acc0_dv;
  logic        acc1_dv;

  assign rx_ready  = !(cmd_valid && !cmd_ready);
  assign accept    = rx_valid && rx_ready;
  assign state_dbg = state;

  assign acc_clear = accept && (state == ST_ESC) && (rx_data == LBRACKET);
  assign acc0_dv   = accept && (state == ST_CSI_P0) && is_digit(rx_data);
  assign acc1_dv   = accept && (state == ST_CSI_P1) && is_digit(rx_data);

  cls_param_acc u_acc0 (
    .clk         (CLK),
    .rst         (RST),
    .clear       (acc_clear),
    .digit_valid (acc0_dv),
    .digit       (rx_data[3:0]),
    .value       (acc0)
  );

  cls_param_acc u_acc1 (
    .clk         (CLK),
    .rst         (RST),
    .clear       (acc_clear),
    .digit_valid (acc1_dv),
    .digit       (rx_data[3:0]),
    .value       (acc1)
  );

  // Byte decode for the current state; only takes effect on an accept.
  always_comb begin
    nxt_state = state;
    emit      = 1'b0;
    emit_code = CMD_ERR;
    emit_p0   = rx_data;
    emit_p1   = 8'd0;
    case (state)
      ST_IDLE: begin
        if (rx_data == ESC) begin
          nxt_state = ST_ESC;
        end else if (is_printable(rx_data)) begin
          emit      = 1'b1;
          emit_code = CMD_CHAR;
        end
      end
      ST_ESC: begin
        if (rx_data == LBRACKET) begin
          nxt_state = ST_CSI_P0;
        end else if (rx_data != ESC) begin
          emit      = 1'b1;
          nxt_state = ST_IDLE;
        end
      end
      ST_CSI_P0, ST_CSI_P1: begin
        if (is_digit(rx_data)) begin
          nxt_state = state;
        end else if (rx_data == SEMI) begin
          if (state == ST_CSI_P0) begin
            nxt_state = ST_CSI_P1;
          end else begin
            emit      = 1'b1;
            nxt_state = ST_IDLE;
          end
        end else if (rx_data == ESC) begin
          nxt_state = ST_ESC;
        end else begin
          emit      = 1'b1;
          emit_code = csi_final_code(rx_data);
          nxt_state = ST_IDLE;
          if (emit_code != CMD_ERR) begin
            emit_p0 = acc0;
            emit_p1 = acc1;
          end
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      to_cnt    <= 16'd0;
      cmd_valid <= 1'b0;
      cmd_code  <= 4'd0;
      cmd_p0    <= 8'd0;
      cmd_p1    <= 8'd0;
      seq_abort <= 1'b0;
    end else begin
      seq_abort <= 1'b0;
      if (cmd_ready) begin
        cmd_valid <= 1'b0;
      end
      if (accept) begin
        state  <= nxt_state;
        to_cnt <= 16'd0;
        if (emit) begin
          cmd_valid <= 1'b1;
          cmd_code  <= emit_code;
          cmd_p0    <= emit_p0;
          cmd_p1    <= emit_p1;
        end
      end else if (state != ST_IDLE) begin
        if (to_cnt == TO_LAST) begin
          state     <= ST_IDLE;
          to_cnt    <= 16'd0;
          seq_abort <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 16'd1;
        end
      end else begin
        to_cnt <= 16'd0;
      end
    end
  end

endmodule

// File: tb/tb_cls_command_parser.sv
// Bench for cls_command_parser: table of byte sequences with expected
// commands, plus hand-written stall, timeout and reset sequences.
module tb_cls_command_parser;
  import cls_pkg::*;

  logic       CLK;
  logic       RST;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_code;
  logic [7:0] cmd_p0;
  logic [7:0] cmd_p1;
  logic       seq_abort;
  state_t     state_dbg;

  int n_vec = 0;
  int n_err = 0;
  logic [19:0] exp_q[$];

  typedef struct {
    logic [79:0] bytes;
    int          len;
    logic        has_cmd;
    logic [3:0]  code;
    logic [7:0]  p0;
    logic [7:0]  p1;
  } vec_t;

  vec_t vecs[16];

  cls_command_parser #(.TIMEOUT(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_code  (cmd_code),
    .cmd_p0    (cmd_p0),
    .cmd_p1    (cmd_p1),
    .seq_abort (seq_abort),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors so far", n_vec);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Driver tasks
  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    @(negedge CLK);
    rx_data  = b;
    rx_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      #1;
      if (rx_ready) begin
        @(posedge CLK);
        done = 1'b1;
      end else begin
        @(negedge CLK);
      end
    end
    if (!done) check("rx_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic rx_idle();
    @(negedge CLK);
    rx_valid = 1'b0;
  endtask

  task automatic set_ready(input logic r);
    @(posedge CLK);
    #2;
    cmd_ready = r;
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    rx_valid = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    check({tag, "_cmd_fields"}, {12'd0, cmd_code, cmd_p0, cmd_p1}, 32'd0);
    check({tag, "_seq_abort"}, 32'(seq_abort), 32'd0);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
    check({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
  endtask

  // Scoreboard: every completed cmd handshake must match the queue head.
  always @(negedge CLK) begin
    if (!RST && cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_cmd: got code=%h p0=%h p1=%h, expected none",
                 cmd_code, cmd_p0, cmd_p1);
      end else begin
        check("cmd", {12'd0, cmd_code, cmd_p0, cmd_p1}, {12'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    logic [79:0] bb;
    int          n;

    vecs[0]  = '{80'h1B5B6A,               3,  1'b1, CMD_CLEAR,      8'h00, 8'h00};
    vecs[1]  = '{80'h1B5B313B313248,       7,  1'b1, CMD_CURSOR,     8'h01, 8'h0C};
    vecs[2]  = '{80'h1B5B3330303B3748,     8,  1'b1, CMD_CURSOR,     8'hFF, 8'h07};
    vecs[3]  = '{80'h1B41,                 2,  1'b1, CMD_ERR,        8'h41, 8'h00};
    vecs[4]  = '{80'h1B5B313B323B,         6,  1'b1, CMD_ERR,        8'h3B, 8'h00};
    vecs[5]  = '{80'h0D,                   1,  1'b0, CMD_CHAR,       8'h00, 8'h00};
    vecs[6]  = '{80'h1B5B3939394B,         6,  1'b1, CMD_ERASE_LINE, 8'hFF, 8'h00};
    vecs[7]  = '{80'h1B5B3B3548,           5,  1'b1, CMD_CURSOR,     8'h00, 8'h05};
    vecs[8]  = '{80'h1B5B48,               3,  1'b1, CMD_CURSOR,     8'h00, 8'h00};
    vecs[9]  = '{80'h1B5B3268,             4,  1'b1, CMD_SET_MODE,   8'h02, 8'h00};
    vecs[10] = '{80'h7E,                   1,  1'b1, CMD_CHAR,       8'h7E, 8'h00};
    vecs[11] = '{80'h1B5B311B5B346A,       7,  1'b1, CMD_CLEAR,      8'h04, 8'h00};
    vecs[12] = '{80'h1B1B5B6A,             4,  1'b1, CMD_CLEAR,      8'h00, 8'h00};
    vecs[13] = '{80'h1B5B3278,             4,  1'b1, CMD_ERR,        8'h78, 8'h00};
    vecs[14] = '{80'h80,                   1,  1'b0, CMD_CHAR,       8'h00, 8'h00};
    vecs[15] = '{80'h1B5B3235343B32353648, 10, 1'b1, CMD_CURSOR,     8'hFE, 8'hFF};

    RST       = 1'b1;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    cmd_ready = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    #1;
    check_reset_state("reset");

    // Latency: CLEAR appears exactly one edge after 6A is accepted.
    send_byte(8'h1B);
    send_byte(8'h5B);
    #1;
    check("clear_pre_valid", 32'(cmd_valid), 32'd0);
    exp_q.push_back({CMD_CLEAR, 8'h00, 8'h00});
    send_byte(8'h6A);
    #1;
    check("clear_lat1", {31'd0, cmd_valid}, 32'd1);
    check("clear_code", 32'(cmd_code), 32'(CMD_CLEAR));
    rx_idle();
    @(negedge CLK);
    check("clear_single", 32'(cmd_valid), 32'd0);

    // Table-driven vectors
    for (int i = 0; i < 16; i++) begin
      bb = vecs[i].bytes;
      n  = vecs[i].len;
      if (vecs[i].has_cmd) exp_q.push_back({vecs[i].code, vecs[i].p0, vecs[i].p1});
      for (int j = 0; j < n; j++) send_byte(bb[8*(n-1-j) +: 8]);
      rx_idle();
      repeat (3) @(negedge CLK);
      check($sformatf("vec%0d_drain", i), 32'(exp_q.size()), 32'd0);
    end

    // Backpressure: 'A' held while stalled, 'B' waits, then both delivered.
    set_ready(1'b0);
    exp_q.push_back({CMD_CHAR, 8'h41, 8'h00});
    exp_q.push_back({CMD_CHAR, 8'h42, 8'h00});
    send_byte(8'h41);
    @(negedge CLK);
    rx_data  = 8'h42;
    rx_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("stall%0d_hold", k), {12'd0, cmd_code, cmd_p0, 7'd0, cmd_valid},
            {12'd0, CMD_CHAR, 8'h41, 8'h01});
      check($sformatf("stall%0d_rx_ready", k), 32'(rx_ready), 32'd0);
      @(negedge CLK);
    end
    set_ready(1'b1);
    #1;
    check("release_rx_ready", {31'd0, rx_ready}, 32'd1);
    @(posedge CLK);
    rx_idle();
    repeat (3) @(negedge CLK);
    check("stall_drain", 32'(exp_q.size()), 32'd0);

    // Timeout: abort pulses once, at the 8th idle edge, with no command.
    send_byte(8'h1B);
    send_byte(8'h5B);
    rx_idle();
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      check($sformatf("abort_idle%0d", k), 32'(seq_abort), (k == 8) ? 32'd1 : 32'd0);
    end
    check("abort_state", 32'(state_dbg), 32'(ST_IDLE));
    exp_q.push_back({CMD_CHAR, 8'h5A, 8'h00});
    send_byte(8'h5A);
    rx_idle();
    repeat (3) @(negedge CLK);
    check("after_abort_drain", 32'(exp_q.size()), 32'd0);

    // Reset with a CHAR pending discards it.
    set_ready(1'b0);
    send_byte(8'h51);
    pulse_reset();
    #1;
    check_reset_state("rst_pending");
    set_ready(1'b1);

    // Reset mid-CSI: following 'j' is a plain CHAR, not CLEAR.
    send_byte(8'h1B);
    send_byte(8'h5B);
    send_byte(8'h32);
    pulse_reset();
    #1;
    check_reset_state("rst_midseq");
    exp_q.push_back({CMD_CHAR, 8'h6A, 8'h00});
    send_byte(8'h6A);
    rx_idle();
    repeat (3) @(negedge CLK);
    check("rst_midseq_drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
